// File: rtl/fir_mac_seq_pkg.sv
// Shared definitions for the sequential single-MAC FIR engines: default
// geometry of the tap bus, FSM state encoding and small sizing helpers.
package fir_mac_seq_pkg;

    // Default geometry of the shared tap bus
    localparam int BITS_PER_ELEM_DEF = 8;
    localparam int NUM_TAPS_DEF      = 9;
    localparam int TOTAL_BITS_DEF    = NUM_TAPS_DEF * BITS_PER_ELEM_DEF;
    localparam int COEF_BITS_DEF     = 8;
    localparam int OUT_BITS_DEF      = 8;

    // Offset-binary tap elements carry their inverted sign in this bit
    localparam int OB_MSB_DEF = BITS_PER_ELEM_DEF - 1;

    // Engine sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    // Accumulator width: full product width plus headroom for summing all taps
    function automatic int acc_bits(input int elem_bits, input int coef_bits, input int num_taps);
        return elem_bits + coef_bits + $clog2(num_taps);
    endfunction

    // Tap index counter width, never narrower than one bit
    function automatic int idx_bits(input int num_taps);
        return (num_taps > 1) ? $clog2(num_taps) : 1;
    endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Start/tap request and result bundle between the tap shift register side
// and one FIR engine. The engine is the slave; the tap source is the master.
interface fir_mac_seq_if #(
    parameter int TOTAL_BITS = 72,
    parameter int OUT_BITS   = 8
);

    logic                        i_start_calc;
    logic [TOTAL_BITS-1:0]       i_taps;
    logic signed [OUT_BITS-1:0]  o_value;
    logic                        o_valid;
    logic                        o_busy;
    logic                        o_dropped;

    modport master (
        output i_start_calc,
        output i_taps,
        input  o_value,
        input  o_valid,
        input  o_busy,
        input  o_dropped
    );

    modport slave (
        input  i_start_calc,
        input  i_taps,
        output o_value,
        output o_valid,
        output o_busy,
        output o_dropped
    );

endinterface

// File: rtl/fir_mac_seq_round_sat.sv
// Combinational round-half-up + arithmetic right shift + signed saturation.
// Kept separate so sibling band filters can reuse the same output stage.
module fir_round_sat #(
    parameter int IN_BITS  = 20,
    parameter int SHIFT    = 0,
    parameter int OUT_BITS = 8
) (
    input  logic signed [IN_BITS-1:0]  din,
    output logic signed [OUT_BITS-1:0] dout
);

    // One guard bit so adding the rounding constant can never wrap
    localparam int EXT_W   = IN_BITS + 1;
    localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EXT_W-1:0] HALF =
        (SHIFT > 0) ? (EXT_W'(1) <<< HALF_SH) : '0;

    // Saturation only matters when the output is narrower than the rounded value
    localparam bit NEED_SAT = (OUT_BITS < EXT_W);

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        EXT_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [EXT_W-1:0] round_fn(input logic signed [IN_BITS-1:0] x);
        logic signed [EXT_W-1:0] xe;
        xe = EXT_W'(x);
        return (xe + HALF) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_BITS-1:0] sat_fn(input logic signed [EXT_W-1:0] x);
        logic signed [OUT_BITS-1:0] y;
        if (!NEED_SAT) begin
            y = OUT_BITS'(x);
        end else if (x > SAT_MAX) begin
            y = OUT_BITS'(SAT_MAX);
        end else if (x < SAT_MIN) begin
            y = OUT_BITS'(SAT_MIN);
        end else begin
            y = OUT_BITS'(x);
        end
        return y;
    endfunction

    // Output stage: round first, then clamp into the signed output range
    always_comb begin
        dout = sat_fn(round_fn(din));
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential single-MAC FIR engine. On a start pulse it snapshots the packed
// offset-binary tap window, accumulates one tap*coefficient product per clock
// through a single multiplier, then presents one rounded, saturated sample
// with a one-cycle valid strobe. Starts arriving mid-calculation are dropped
// and flagged; a start arriving in the result cycle is accepted directly.
module fir_mac_seq
    import fir_mac_seq_pkg::*;
#(
    parameter int BITS_PER_ELEM = BITS_PER_ELEM_DEF,
    parameter int NUM_TAPS      = NUM_TAPS_DEF,
    parameter int TOTAL_BITS    = NUM_TAPS * BITS_PER_ELEM,
    parameter int COEF_BITS     = COEF_BITS_DEF,
    parameter logic [NUM_TAPS*COEF_BITS-1:0] COEFFS = '0,
    parameter int SHIFT         = 0,
    parameter int OUT_BITS      = OUT_BITS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fir_mac_seq_if.slave  bus
);

    localparam int ACC_BITS = acc_bits(BITS_PER_ELEM, COEF_BITS, NUM_TAPS);
    localparam int IDX_W    = idx_bits(NUM_TAPS);
    localparam int PROD_W   = BITS_PER_ELEM + COEF_BITS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    fir_state_t                  state;
    logic [IDX_W-1:0]            idx;
    logic signed [ACC_BITS-1:0]  acc;
    logic [TOTAL_BITS-1:0]       snap;
    logic signed [OUT_BITS-1:0]  value_p0;
    logic                        vld_p0;
    logic                        busy_p0;
    logic                        dropped_p0;

    logic [BITS_PER_ELEM-1:0]    tap_sel;
    logic signed [BITS_PER_ELEM-1:0] tap_s;
    logic signed [COEF_BITS-1:0] coef_s;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_BITS-1:0]  acc_next;
    logic signed [OUT_BITS-1:0]  rs_out;

    // Tap/coefficient mux feeding the single multiplier; offset-binary tap
    // becomes two's complement by flipping its MSB
    always_comb begin
        tap_sel  = snap[int'(idx)*BITS_PER_ELEM +: BITS_PER_ELEM];
        tap_s    = {~tap_sel[BITS_PER_ELEM-1], tap_sel[BITS_PER_ELEM-2:0]};
        coef_s   = COEFFS[int'(idx)*COEF_BITS +: COEF_BITS];
        prod     = PROD_W'(tap_s) * PROD_W'(coef_s);
        acc_next = acc + ACC_BITS'(prod);
    end

    fir_round_sat #(
        .IN_BITS  (ACC_BITS),
        .SHIFT    (SHIFT),
        .OUT_BITS (OUT_BITS)
    ) u_round_sat (
        .din  (acc),
        .dout (rs_out)
    );

    // Sequencer: snapshot on start, one MAC per cycle, publish result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            snap       <= '0;
            value_p0   <= '0;
            vld_p0     <= 1'b0;
            busy_p0    <= 1'b0;
            dropped_p0 <= 1'b0;
        end else begin
            vld_p0     <= 1'b0;
            dropped_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start_calc) begin
                        snap    <= bus.i_taps;
                        acc     <= '0;
                        idx     <= '0;
                        busy_p0 <= 1'b1;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    // A window offered while computing is lost, not queued
                    if (bus.i_start_calc) begin
                        dropped_p0 <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        busy_p0 <= 1'b0;
                        state   <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    value_p0 <= rs_out;
                    vld_p0   <= 1'b1;
                    // Back-to-back windows: accept a start here as if idle
                    if (bus.i_start_calc) begin
                        snap    <= bus.i_taps;
                        acc     <= '0;
                        idx     <= '0;
                        busy_p0 <= 1'b1;
                        state   <= MAC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy_p0 <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_value   = value_p0;
    assign bus.o_valid   = vld_p0;
    assign bus.o_busy    = busy_p0;
    assign bus.o_dropped = dropped_p0;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: four engines with different coefficient/shift
// configurations share one start/tap stimulus and are compared against an
// arithmetic model of the filter.
module tb_fir_mac_seq;

    localparam int B  = 8;
    localparam int N  = 9;
    localparam int TB = N * B;
    localparam int C  = 8;
    localparam int OB = 8;

    localparam logic [N*C-1:0] CO_ONE = {9{8'd1}};
    localparam logic [N*C-1:0] CO_127 = {9{8'd127}};
    localparam logic [N*C-1:0] CO_D   = {8'd7, 8'hF0, 8'd25, 8'h81, 8'd127, 8'hFB, 8'd64, 8'hC0, 8'd1};
    localparam int SH_D = 6;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [TB-1:0] taps;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_mac_seq_if #(.TOTAL_BITS(TB), .OUT_BITS(OB)) ifa ();
    fir_mac_seq_if #(.TOTAL_BITS(TB), .OUT_BITS(OB)) ifb ();
    fir_mac_seq_if #(.TOTAL_BITS(TB), .OUT_BITS(OB)) ifc ();
    fir_mac_seq_if #(.TOTAL_BITS(TB), .OUT_BITS(OB)) ifd ();

    assign ifa.i_start_calc = start;
    assign ifb.i_start_calc = start;
    assign ifc.i_start_calc = start;
    assign ifd.i_start_calc = start;
    assign ifa.i_taps = taps;
    assign ifb.i_taps = taps;
    assign ifc.i_taps = taps;
    assign ifd.i_taps = taps;

    fir_mac_seq #(.BITS_PER_ELEM(B), .NUM_TAPS(N), .TOTAL_BITS(TB), .COEF_BITS(C),
                  .COEFFS(CO_ONE), .SHIFT(0), .OUT_BITS(OB))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    fir_mac_seq #(.BITS_PER_ELEM(B), .NUM_TAPS(N), .TOTAL_BITS(TB), .COEF_BITS(C),
                  .COEFFS(CO_127), .SHIFT(0), .OUT_BITS(OB))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    fir_mac_seq #(.BITS_PER_ELEM(B), .NUM_TAPS(N), .TOTAL_BITS(TB), .COEF_BITS(C),
                  .COEFFS(CO_ONE), .SHIFT(2), .OUT_BITS(OB))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));
    fir_mac_seq #(.BITS_PER_ELEM(B), .NUM_TAPS(N), .TOTAL_BITS(TB), .COEF_BITS(C),
                  .COEFFS(CO_D), .SHIFT(SH_D), .OUT_BITS(OB))
        dut_d (.clk(clk), .rst(rst), .bus(ifd));

    // Filter result straight from the arithmetic definition
    function automatic longint model(input logic [TB-1:0] t, input logic [N*C-1:0] co, input int sh);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += (longint'(t[k*B +: B]) - 128) * longint'($signed(co[k*C +: C]));
        end
        if (sh > 0) r = (acc + (longint'(1) << (sh - 1))) >>> sh;
        else        r = acc;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic [TB-1:0] rand_taps();
        logic [TB-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k*B +: B] = 8'($urandom_range(0, 255));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One start, checks latency, busy length, all four results and strobe width
    task automatic run_window(input logic [TB-1:0] t, input string tag);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        taps  = t;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) taps = ~t;
            if (ifa.o_busy) busy_cnt++;
            if (ifa.o_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_busy_cycles"}, busy_cnt, 9);
        chk({tag, "_val_a"}, ifa.o_value, model(t, CO_ONE, 0));
        chk({tag, "_val_b"}, ifb.o_value, model(t, CO_127, 0));
        chk({tag, "_val_c"}, ifc.o_value, model(t, CO_ONE, 2));
        chk({tag, "_val_d"}, ifd.o_value, model(t, CO_D, SH_D));
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, ifa.o_valid, 0);
    endtask

    initial begin
        logic [TB-1:0] t1;
        logic [TB-1:0] t2;
        int nd, nv, dk, vk, vk2;
        logic signed [OB-1:0] va, vd, va2;

        rst   = 1'b1;
        start = 1'b0;
        taps  = '0;
        repeat (3) @(negedge clk);
        chk("reset_value", ifa.o_value, 0);
        chk("reset_valid", ifa.o_valid, 0);
        chk("reset_busy", ifa.o_busy, 0);
        chk("reset_dropped", ifa.o_dropped, 0);
        rst = 1'b0;

        run_window({9{8'h80}}, "zero_taps");
        chk("zero_taps_const", ifa.o_value, 0);

        run_window({9{8'h81}}, "plus_one");
        chk("plus_one_const", ifa.o_value, 9);
        run_window({9{8'h7F}}, "minus_one");
        chk("minus_one_const", ifa.o_value, -9);

        run_window({9{8'hFF}}, "max_taps");
        chk("sat_high_const", ifb.o_value, 127);
        run_window({9{8'h00}}, "min_taps");
        chk("sat_low_const", ifb.o_value, -128);

        run_window({{3{8'h80}}, {6{8'h81}}}, "round_pos");
        chk("round_pos_const", ifc.o_value, 2);
        run_window({{3{8'h80}}, {6{8'h7F}}}, "round_neg");
        chk("round_neg_const", ifc.o_value, -1);

        for (int i = 0; i < 12; i++) begin
            run_window(rand_taps(), $sformatf("rand%0d", i));
        end

        // Start while busy is dropped, in-flight result unaffected
        t1 = rand_taps();
        t2 = rand_taps();
        nd = 0; nv = 0; dk = 0; vk = 0; va = '0; vd = '0;
        @(negedge clk);
        start = 1'b1;
        taps  = t1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; taps = t2; end
            if (k == 4) start = 1'b0;
            if (ifa.o_dropped) begin nd++; dk = k; end
            if (ifa.o_valid) begin nv++; vk = k; va = ifa.o_value; vd = ifd.o_value; end
        end
        chk("drop_count", nd, 1);
        chk("drop_cycle", dk, 4);
        chk("drop_valid_count", nv, 1);
        chk("drop_valid_cycle", vk, 11);
        chk("drop_val_a", va, model(t1, CO_ONE, 0));
        chk("drop_val_d", vd, model(t1, CO_D, SH_D));

        // Start coincident with DONE is accepted back-to-back
        t1 = rand_taps();
        t2 = rand_taps();
        nd = 0; nv = 0; vk = 0; vk2 = 0; va = '0; va2 = '0; vd = '0;
        @(negedge clk);
        start = 1'b1;
        taps  = t1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) begin start = 1'b1; taps = t2; end
            if (k == 11) start = 1'b0;
            if (ifa.o_dropped) nd++;
            if (ifa.o_valid) begin
                nv++;
                if (nv == 1) begin vk = k; va = ifa.o_value; end
                else begin vk2 = k; va2 = ifa.o_value; vd = ifd.o_value; end
            end
        end
        chk("b2b_valid_count", nv, 2);
        chk("b2b_first_cycle", vk, 11);
        chk("b2b_spacing", vk2 - vk, 10);
        chk("b2b_no_drop", nd, 0);
        chk("b2b_val1_a", va, model(t1, CO_ONE, 0));
        chk("b2b_val2_a", va2, model(t2, CO_ONE, 0));
        chk("b2b_val2_d", vd, model(t2, CO_D, SH_D));

        // Asynchronous reset in the middle of a window
        run_window({9{8'h81}}, "pre_abort");
        @(negedge clk);
        start = 1'b1;
        taps  = rand_taps();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("abort_busy_before", ifa.o_busy, 1);
        chk("abort_value_before", ifa.o_value, 9);
        #1 rst = 1'b1;
        #1;
        chk("abort_async_value", ifa.o_value, 0);
        chk("abort_async_busy", ifa.o_busy, 0);
        chk("abort_async_valid", ifa.o_valid, 0);
        chk("abort_async_dropped", ifa.o_dropped, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (ifa.o_valid || ifd.o_valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        run_window(rand_taps(), "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
